w0rm_alu_divrem_seq: RTL and testbench
======================================

W0RM_ALU_DIVREM_SEQ -- requirements
Module: w0rm_alu_divrem_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (>=4).
REQ-002 SHALL have parameter SIGNED_SUPPORT, default 1; 0 makes signed_op ignored (all ops unsigned).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_valid  input  1  request strobe, accepted only when busy=0.
REQ-006 SHALL have port opcode  input  4  4'h6 DIV, 4'h7 REM; other values are illegal.
REQ-007 SHALL have port signed_op  input  1  1 = two's-complement operands.
REQ-008 SHALL have port data_a  input  DATA_WIDTH  dividend.
REQ-009 SHALL have port data_b  input  DATA_WIDTH  divisor.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port result  output  DATA_WIDTH  quotient or remainder, held until next result.
REQ-012 SHALL have port result_valid  output  1  one-cycle strobe, result and flags valid.
REQ-013 SHALL have port result_flags  output  4  bit0 ZERO, bit1 NEG, bit2 OVER, bit3 CARRY.

Function
REQ-014 SHALL use FSM states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-015 IDLE + data_valid SHALL capture opcode, signed_op, operand magnitudes and sign bits on the same edge (E0).
REQ-016 data_valid while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-017 Normal operation SHALL enter CALC and perform one radix-2 restoring step per cycle for exactly DATA_WIDTH cycles, counted by a clog2(DATA_WIDTH+1)-bit counter.
REQ-018 After the last CALC step SHALL enter FIX: apply sign correction, select quotient/remainder by opcode, register result and flags, return to IDLE.
REQ-019 result_valid SHALL be high for exactly the one cycle after the FIX edge, i.e. DATA_WIDTH+1 cycles after E0.
REQ-020 A new data_valid during the result_valid cycle SHALL be accepted (back-to-back, throughput DATA_WIDTH+2 cycles).
REQ-021 Signed quotient SHALL truncate toward zero; signed remainder SHALL take the dividend's sign.
REQ-022 Divide by zero SHALL skip CALC (IDLE->FIX): DIV result all-ones, REM result = data_a; OVER=1; result_valid 1 cycle after E0.
REQ-023 Signed MIN / -1 SHALL skip CALC: DIV result MIN, REM result 0; OVER=1; result_valid 1 cycle after E0.
REQ-024 Illegal opcode SHALL skip CALC and produce result 0, ZERO=1, OVER=1.
REQ-025 ZERO SHALL equal (result==0); NEG SHALL equal result MSB when the op is signed, else 0; CARRY SHALL always be 0.
REQ-026 OVER SHALL be 0 except per REQ-022..REQ-024.
REQ-027 result and result_flags SHALL change only on the FIX edge.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, counter 0, busy 0, result_valid 0, result 0, result_flags 0, all operand registers 0.
REQ-029 Reset during CALC/FIX SHALL abort the operation with no result_valid strobe; first edge after release in IDLE SHALL accept data_valid.

Structure
REQ-030 Opcode constants (DIV 4'h6, REM 4'h7) and flag bit indices SHALL reside in shared package w0rm_alu_pkg.
REQ-031 One combinational sub-module w0rm_div_step (partial remainder, divisor -> next remainder, quotient bit) SHALL be instantiated once.

Verification (DATA_WIDTH=8)
REQ-032 Unsigned DIV 100/7 -> result 0x0E, flags 0000, result_valid exactly 9 cycles after accept; REM -> 0x02.
REQ-033 Signed DIV 0xF9/0x02 (-7/2) -> 0xFD, NEG=1; signed REM -> 0xFF, NEG=1.
REQ-034 DIV 0x55/0x00 -> 0xFF, OVER=1, 1-cycle latency; REM 0x55/0x00 -> 0x55, OVER=1.
REQ-035 Signed DIV 0x80/0xFF -> 0x80, OVER=1, NEG=1; signed REM -> 0x00, ZERO=1, OVER=1.
REQ-036 data_valid held high continuously with changing operands -> only ops presented in idle/result_valid cycles are executed, each result correct, spacing 10 cycles.
REQ-037 reset_n pulsed low at cycle 4 of CALC -> busy, result_valid, result drop to 0 immediately; no stale strobe; next op 20/3 -> 0x06.

Source files
------------

// File: rtl/w0rm_alu_pkg.sv
// Shared ALU constants: divide/remainder opcodes, result flag bit positions,
// and the state/special-case encodings used by the sequential divider.
package w0rm_alu_pkg;

   localparam logic [3:0] OP_DIV = 4'h6;
   localparam logic [3:0] OP_REM = 4'h7;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_NEG   = 1;
   localparam int FLAG_OVER  = 2;
   localparam int FLAG_CARRY = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } divrem_state_t;

   // Operations that bypass the iterative loop and resolve directly in FIX
   typedef enum logic [1:0] {
      SP_NONE,
      SP_DIV0,
      SP_OVFL,
      SP_ILLEGAL
   } divrem_special_t;

endpackage

// File: rtl/w0rm_div_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the
// shifted partial remainder, keep the difference when it does not go negative.
module w0rm_div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   part_rem,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         q_bit
);

   logic [W:0] diff;

   // part_rem < 2*divisor, so the top bit of the difference is a clean borrow
   assign diff     = part_rem - {1'b0, divisor};
   assign q_bit    = ~diff[W];
   assign rem_next = q_bit ? diff[W-1:0] : part_rem[W-1:0];

endmodule

// File: rtl/w0rm_alu_divrem_seq.sv
// Sequential signed/unsigned DIV/REM unit: magnitude restoring divider, one
// quotient bit per cycle, sign fix-up and special-case resolution in FIX.
module w0rm_alu_divrem_seq
   import w0rm_alu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter bit SIGNED_SUPPORT = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  data_valid,
   input  logic [3:0]            opcode,
   input  logic                  signed_op,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid,
   output logic [3:0]            result_flags
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   divrem_state_t   state_q, state_d;
   divrem_special_t spec_q, spec_in;
   logic [CW-1:0]   cnt_q;
   logic [3:0]      op_q;
   logic            sgn_q, sa_q, sb_q;
   logic [W-1:0]    dvd_q;   // dividend magnitude, becomes quotient as bits shift in
   logic [W-1:0]    dvs_q;
   logic [W-1:0]    rem_q;

   logic            sgn_in, sa_in, sb_in;
   logic [W-1:0]    mag_a, mag_b;
   logic [W-1:0]    rem_nx;
   logic            q_bit;
   logic [W-1:0]    fix_res;
   logic [3:0]      fix_flags;
   logic [W-1:0]    q_fix, r_fix, a_orig;

   assign busy   = (state_q != ST_IDLE);
   assign sgn_in = signed_op & SIGNED_SUPPORT;
   assign sa_in  = sgn_in & data_a[W-1];
   assign sb_in  = sgn_in & data_b[W-1];
   assign mag_a  = sa_in ? -data_a : data_a;
   assign mag_b  = sb_in ? -data_b : data_b;

   always_comb begin
      spec_in = SP_NONE;
      if (opcode != OP_DIV && opcode != OP_REM)
         spec_in = SP_ILLEGAL;
      else if (data_b == '0)
         spec_in = SP_DIV0;
      else if (sgn_in && data_a == MIN_VAL && &data_b)
         spec_in = SP_OVFL;
   end

   w0rm_div_step #(.W(W)) u_step (
      .part_rem (({rem_q, dvd_q[W-1]})),
      .divisor  (dvs_q),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (data_valid) state_d = (spec_in == SP_NONE) ? ST_CALC : ST_FIX;
         ST_CALC: if (cnt_q == CW'(1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Special cases never enter CALC, so dvd_q still holds |a| for REM-by-zero
   assign q_fix  = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
   assign r_fix  = sa_q ? -rem_q : rem_q;
   assign a_orig = sa_q ? -dvd_q : dvd_q;

   always_comb begin
      fix_res = '0;
      case (spec_q)
         SP_NONE:    fix_res = (op_q == OP_DIV) ? q_fix : r_fix;
         SP_DIV0:    fix_res = (op_q == OP_DIV) ? '1 : a_orig;
         SP_OVFL:    fix_res = (op_q == OP_DIV) ? MIN_VAL : '0;
         SP_ILLEGAL: fix_res = '0;
         default:    fix_res = '0;
      endcase
      fix_flags             = '0;
      fix_flags[FLAG_ZERO]  = (fix_res == '0);
      fix_flags[FLAG_NEG]   = sgn_q & fix_res[W-1];
      fix_flags[FLAG_OVER]  = (spec_q != SP_NONE);
      fix_flags[FLAG_CARRY] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         spec_q       <= SP_NONE;
         cnt_q        <= '0;
         op_q         <= '0;
         sgn_q        <= 1'b0;
         sa_q         <= 1'b0;
         sb_q         <= 1'b0;
         dvd_q        <= '0;
         dvs_q        <= '0;
         rem_q        <= '0;
         result       <= '0;
         result_flags <= '0;
         result_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_valid <= 1'b0;
         case (state_q)
            ST_IDLE: if (data_valid) begin
               op_q   <= opcode;
               sgn_q  <= sgn_in;
               sa_q   <= sa_in;
               sb_q   <= sb_in;
               dvd_q  <= mag_a;
               dvs_q  <= mag_b;
               rem_q  <= '0;
               spec_q <= spec_in;
               cnt_q  <= CW'(DATA_WIDTH);
            end
            ST_CALC: begin
               rem_q <= rem_nx;
               dvd_q <= {dvd_q[W-2:0], q_bit};
               cnt_q <= cnt_q - CW'(1);
            end
            ST_FIX: begin
               result       <= fix_res;
               result_flags <= fix_flags;
               result_valid <= 1'b1;
               cnt_q        <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_w0rm_alu_divrem_seq.sv
// Randomised self-checking bench for the sequential DIV/REM unit (8-bit):
// integer-arithmetic reference model, cycle-exact scoreboard, directed corners.
module tb_w0rm_alu_divrem_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         data_valid = 1'b0;
   logic [3:0]   opcode = 4'h6;
   logic         signed_op = 1'b0;
   logic [W-1:0] data_a = '0;
   logic [W-1:0] data_b = '0;
   logic         busy;
   logic [W-1:0] result;
   logic         result_valid;
   logic [3:0]   result_flags;

   w0rm_alu_divrem_seq #(.DATA_WIDTH(W), .SIGNED_SUPPORT(1'b1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_valid   (data_valid),
      .opcode       (opcode),
      .signed_op    (signed_op),
      .data_a       (data_a),
      .data_b       (data_b),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_flags (result_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   fl;
      int           due;
   } exp_t;

   exp_t         expq[$];
   int           edge_n = 0;
   int           free_at = 0;
   logic [W-1:0] last_res = '0;
   logic [3:0]   last_fl = '0;
   int           checks = 0;
   int           failures = 0;
   bit           got = 0;
   logic [W-1:0] got_res;
   logic [3:0]   got_fl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Reference: plain integer division with the documented special cases
   function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] op, input bit sg,
                                  output logic [W-1:0] res, output logic [3:0] fl,
                                  output int lat);
      int  ia, ib, q, r;
      bit  over;
      over = 0;
      lat  = W + 1;
      if (op != 4'h6 && op != 4'h7) begin
         res = '0; over = 1; lat = 1;
      end else if (b == 0) begin
         res = (op == 4'h6) ? 8'hFF : a; over = 1; lat = 1;
      end else if (sg && a == 8'h80 && b == 8'hFF) begin
         res = (op == 4'h6) ? 8'h80 : 8'h00; over = 1; lat = 1;
      end else begin
         if (sg) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
         end else begin
            ia = int'(a);
            ib = int'(b);
         end
         q = ia / ib;
         r = ia % ib;
         res = (op == 4'h6) ? q[W-1:0] : r[W-1:0];
      end
      fl = {1'b0, over, sg & res[W-1], res == 0};
   endfunction

   // Acceptance model: a request is taken on any edge where the unit is idle
   always @(posedge clk) begin
      logic [W-1:0] r;
      logic [3:0]   f;
      int           lat;
      edge_n++;
      if (reset_n && data_valid && edge_n >= free_at) begin
         ref_op(data_a, data_b, opcode, signed_op, r, f, lat);
         expq.push_back('{res: r, fl: f, due: edge_n + lat});
         free_at = edge_n + lat + 1;
      end
   end

   // Cycle-by-cycle comparison, sampled mid-cycle
   always @(negedge clk) begin
      if (reset_n) begin
         check("busy", busy, (edge_n < free_at - 1));
         if (expq.size() > 0 && expq[0].due == edge_n) begin
            last_res = expq[0].res;
            last_fl  = expq[0].fl;
            void'(expq.pop_front());
            check("result_valid_strobe", result_valid, 1'b1);
         end else begin
            check("result_valid_idle", result_valid, 1'b0);
         end
         check("result", result, last_res);
         check("result_flags", result_flags, last_fl);
         if (result_valid) begin
            got     = 1;
            got_res = result;
            got_fl  = result_flags;
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op, input bit sg);
      @(posedge clk); #1;
      data_a = a; data_b = b; opcode = op; signed_op = sg; data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
   endtask

   task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input bit sg,
                          input logic [W-1:0] er, input logic [3:0] ef);
      int n;
      got = 0;
      send(a, b, op, sg);
      n = 0;
      while (!got && n < 30) begin
         @(negedge clk); #1;
         n++;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no result_valid within 30 cycles", name);
      end else begin
         check({name, "_res"}, got_res, er);
         check({name, "_flags"}, got_fl, ef);
      end
   endtask

   task automatic pin_model(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] op, input bit sg,
                            input logic [W-1:0] er, input logic [3:0] ef, input int el);
      logic [W-1:0] r;
      logic [3:0]   f;
      int           l;
      ref_op(a, b, op, sg, r, f, l);
      check({name, "_model_res"}, r, er);
      check({name, "_model_fl"}, f, ef);
      check({name, "_model_lat"}, l, el);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_valid", result_valid, 1'b0);
      check("rst_result", result, '0);
      check("rst_flags", result_flags, '0);
      expq.delete();
      free_at  = 0;
      last_res = '0;
      last_fl  = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      // Hand-derived values pinning the reference model
      pin_model("udiv100_7", 8'd100, 8'd7, 4'h6, 0, 8'h0E, 4'b0000, 9);
      pin_model("urem100_7", 8'd100, 8'd7, 4'h7, 0, 8'h02, 4'b0000, 9);
      pin_model("sdivm7_2",  8'hF9, 8'h02, 4'h6, 1, 8'hFD, 4'b0010, 9);
      pin_model("sremm7_2",  8'hF9, 8'h02, 4'h7, 1, 8'hFF, 4'b0010, 9);
      pin_model("div0",      8'h55, 8'h00, 4'h6, 0, 8'hFF, 4'b0100, 1);
      pin_model("ovfl_rem",  8'h80, 8'hFF, 4'h7, 1, 8'h00, 4'b0101, 1);

      #2;
      do_reset();

      run_lit("udiv",    8'd100, 8'd7, 4'h6, 0, 8'h0E, 4'b0000);
      run_lit("urem",    8'd100, 8'd7, 4'h7, 0, 8'h02, 4'b0000);
      run_lit("sdiv",    8'hF9, 8'h02, 4'h6, 1, 8'hFD, 4'b0010);
      run_lit("srem",    8'hF9, 8'h02, 4'h7, 1, 8'hFF, 4'b0010);
      run_lit("div0",    8'h55, 8'h00, 4'h6, 0, 8'hFF, 4'b0100);
      run_lit("rem0",    8'h55, 8'h00, 4'h7, 0, 8'h55, 4'b0100);
      run_lit("sovdiv",  8'h80, 8'hFF, 4'h6, 1, 8'h80, 4'b0110);
      run_lit("sovrem",  8'h80, 8'hFF, 4'h7, 1, 8'h00, 4'b0101);
      run_lit("illegal", 8'h12, 8'h03, 4'h3, 0, 8'h00, 4'b0101);
      run_lit("uovfl",   8'h80, 8'hFF, 4'h6, 0, 8'h00, 4'b0001);

      // data_valid held high with operands changing every cycle
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         data_valid = 1'b1;
         opcode     = 4'h6 + 4'($urandom_range(0, 1));
         signed_op  = 1'b0;
         data_a     = 8'($urandom);
         data_b     = 8'($urandom_range(1, 255));
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      repeat (15) @(posedge clk);

      // Abort a division four steps into CALC
      send(8'd100, 8'd7, 4'h6, 0);
      repeat (4) @(posedge clk);
      #3;
      do_reset();
      repeat (15) @(posedge clk);
      run_lit("after_rst", 8'd20, 8'd3, 4'h6, 0, 8'h06, 4'b0000);

      // Random traffic including illegal opcodes, zero divisors, MIN/-1
      for (int i = 0; i < 3000; i++) begin
         int sel;
         @(posedge clk); #1;
         data_valid = ($urandom_range(0, 3) != 0);
         signed_op  = $urandom_range(0, 1) == 1;
         opcode     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h6 + 4'($urandom_range(0, 1));
         data_a     = 8'($urandom);
         data_b     = 8'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0) data_b = 8'h00;
         else if (sel == 1) begin data_a = 8'h80; data_b = 8'hFF; end
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("drain_empty", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
